// File: rtl/dmx_pkg.sv
// Shared definitions for the 1-to-N demultiplexing deserializer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package dmx_pkg;

    // Position source encoding for in_mode.
    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    // FILL collects bits; HOLD presents the finished word until it is taken.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Select width for a given number of positions; a 2-position demux
    // still needs a 1-bit select, so the result never drops below 1.
    function automatic int unsigned sel_w_of(input int unsigned w);
        if (w <= 2) begin
            return 1;
        end
        return $clog2(w);
    endfunction

endpackage

// File: rtl/dmx_pos_decode.sv
// Binary position to one-hot write-enable decoder.
// Latency: combinational, zero cycles.
// Backpressure: none; the enable input gates the whole vector.
module dmx_pos_decode
    import dmx_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0] pos,
    input  logic             en,
    output logic [WIDTH-1:0] wr_vec
);

    // Exactly one bit set at pos when enabled, otherwise all zeros.
    always_comb begin
        wr_vec = '0;
        if (en) begin
            wr_vec[pos] = 1'b1;
        end
    end

endmodule

// File: rtl/dmx16_deser.sv
// Serial-to-parallel demux: one bit per handshake into an addressed or scanned word slot.
// Latency: out_valid rises the cycle after the completing accept (mask full or flush).
// Backpressure: in_ready drops for the whole HOLD phase until out_ready takes the word.
module dmx16_deser
    import dmx_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit DATA_INV = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_data,
    input  logic [sel_w_of(WIDTH)-1:0]    in_sel,
    input  logic                          in_mode,
    input  logic                          in_flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_word,
    output logic [WIDTH-1:0]              out_mask
);

    localparam int SEL_W = sel_w_of(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   cnt;
    logic [SEL_W-1:0]   pos;
    logic               accept;
    logic               bit_val;
    logic               flush_go;
    logic               word_full;
    logic [WIDTH-1:0]   wr_vec;
    logic [WIDTH-1:0]   mask_nxt;
    logic [WIDTH-1:0]   word_nxt;

    // Handshake qualifiers; en_n only gates the fill side.
    assign in_ready  = (state == FILL) & ~en_n;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == HOLD);

    // Scan mode walks the internal counter; addressed mode uses in_sel.
    assign pos     = (in_mode == MODE_SCAN) ? cnt : in_sel;
    assign bit_val = in_data ^ DATA_INV;

    dmx_pos_decode #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_pos_decode (
        .pos    (pos),
        .en     (accept),
        .wr_vec (wr_vec)
    );

    // Word and mask as they would look after this cycle's accept.
    assign mask_nxt  = out_mask | wr_vec;
    assign word_nxt  = (out_word & ~wr_vec) | (wr_vec & {WIDTH{bit_val}});
    assign word_full = accept & (&mask_nxt);

    // A flush closes the word only if something has been (or is being) written.
    assign flush_go  = (state == FILL) & ~en_n & in_flush & (|mask_nxt);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fill until full or flushed, hold until the consumer takes it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL: begin
                if (word_full || flush_go) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Word, mask and scan counter: update on accept, clear when the word is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word <= '0;
            out_mask <= '0;
            cnt      <= '0;
        end else if (state == HOLD) begin
            if (out_ready) begin
                out_word <= '0;
                out_mask <= '0;
                cnt      <= '0;
            end
        end else if (accept) begin
            out_word <= word_nxt;
            out_mask <= mask_nxt;
            if (in_mode == MODE_SCAN) begin
                cnt <= cnt + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmx16_deser.sv
module tb_dmx16_deser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_n;
    logic        in_valid;
    logic        in_data;
    logic [3:0]  in_sel;
    logic        in_mode;
    logic        in_flush;
    logic        out_ready;

    logic        in_ready0, out_valid0;
    logic [15:0] out_word0, out_mask0;
    logic        in_ready1, out_valid1;
    logic [15:0] out_word1, out_mask1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int cyc_a, cyc_b;

    logic [15:0] pat;
    logic [15:0] pat_a;
    logic [15:0] pat_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmx16_deser #(.WIDTH(16), .DATA_INV(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_sel(in_sel), .in_mode(in_mode), .in_flush(in_flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_word(out_word0), .out_mask(out_mask0)
    );

    dmx16_deser #(.WIDTH(16), .DATA_INV(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_sel(in_sel), .in_mode(in_mode), .in_flush(in_flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_word(out_word1), .out_mask(out_mask1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic d, input logic m, input logic [3:0] s);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_sel   = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic flush_only();
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
    endtask

    task automatic release_word();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en_n = 1'b0; in_valid = 1'b0; in_data = 1'b0;
        in_sel = 4'd0; in_mode = 1'b0; in_flush = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_valid", out_valid0, 0);
        check("rst_word",  out_word0, 0);
        check("rst_mask",  out_mask0, 0);
        check("rst_ready", in_ready0, 1);
        rst_n = 1'b1;
        tick();

        // Scan fill: bits LSB-first 1,0,1,1,0,0,0,0,1,1,1,1,0,0,1,0 -> 0x4F0D
        pat = 16'h4F0D;
        for (int i = 0; i < 15; i++) send(pat[i], 1'b1, 4'd0);
        check("scan_not_yet_valid", out_valid0, 0);
        check("scan_mask_15", out_mask0, 16'h7FFF);
        send(pat[15], 1'b1, 4'd0);
        check("scan_valid", out_valid0, 1);
        check("scan_word", out_word0, 16'h4F0D);
        check("scan_mask", out_mask0, 16'hFFFF);
        check("scan_word_inv", out_word1, 16'hB0F2);
        check("scan_hold_ready", in_ready0, 0);
        tick(); tick(); tick();
        check("scan_hold_valid", out_valid0, 1);
        check("scan_hold_word", out_word0, 16'h4F0D);
        release_word();
        check("scan_rel_valid", out_valid0, 0);
        check("scan_rel_word", out_word0, 0);
        check("scan_rel_mask", out_mask0, 0);
        check("scan_rel_ready", in_ready0, 1);

        // Addressed partial word closed by a bit-less flush
        send(1'b1, 1'b0, 4'd3);
        send(1'b1, 1'b0, 4'd15);
        check("addr_pre_valid", out_valid0, 0);
        check("addr_pre_mask", out_mask0, 16'h8008);
        flush_only();
        check("addr_flush_valid", out_valid0, 1);
        check("addr_flush_word", out_word0, 16'h8008);
        check("addr_flush_mask", out_mask0, 16'h8008);
        release_word();
        flush_only();
        check("empty_flush_valid", out_valid0, 0);
        check("empty_flush_ready", in_ready0, 1);

        // Overwrite of position 5: 1 then 0; inverted instance stores 1
        send(1'b1, 1'b0, 4'd5);
        send(1'b0, 1'b0, 4'd5);
        flush_only();
        check("ovw_inv_valid", out_valid1, 1);
        check("ovw_inv_word", out_word1, 16'h0020);
        check("ovw_inv_mask", out_mask1, 16'h0020);
        check("ovw_plain_word", out_word0, 16'h0000);
        check("ovw_plain_mask", out_mask0, 16'h0020);
        release_word();

        // Enable gating: 10 cycles of offered bits with en_n=1, flush in the middle
        send(1'b1, 1'b0, 4'd2);
        en_n = 1'b1; in_valid = 1'b1; in_data = 1'b1; in_mode = 1'b0; in_sel = 4'd9;
        for (int i = 0; i < 10; i++) begin
            in_flush = (i == 5);
            #1;
            check("gate_ready", in_ready0, 0);
            tick();
        end
        in_flush = 1'b0; in_valid = 1'b0; en_n = 1'b0;
        check("gate_mask", out_mask0, 16'h0004);
        check("gate_valid", out_valid0, 0);
        flush_only();
        check("gate_flush_word", out_word0, 16'h0004);
        release_word();

        // Async reset mid-word after 7 scan bits
        for (int i = 0; i < 7; i++) send(1'b1, 1'b1, 4'd0);
        check("pre_rst_mask", out_mask0, 16'h007F);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_word", out_word0, 0);
        check("async_rst_mask", out_mask0, 0);
        check("async_rst_valid", out_valid0, 0);
        rst_n = 1'b1;
        tick();
        send(1'b1, 1'b1, 4'd9);
        check("post_rst_pos0_mask", out_mask0, 16'h0001);
        check("post_rst_pos0_word", out_word0, 16'h0001);
        flush_only();
        release_word();

        // Back-to-back scan words with out_ready tied high
        pat_a = 16'hA5C3;
        pat_b = 16'h1234;
        out_ready = 1'b1;
        in_mode = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = pat_a[i];
            tick();
        end
        cyc_a = cyc;
        check("b2b_a_valid", out_valid0, 1);
        check("b2b_a_word", out_word0, 16'hA5C3);
        check("b2b_a_ready", in_ready0, 0);
        in_data = 1'b1;
        tick();
        check("b2b_bubble_valid", out_valid0, 0);
        for (int i = 0; i < 16; i++) begin
            in_data = pat_b[i];
            tick();
        end
        cyc_b = cyc;
        check("b2b_b_valid", out_valid0, 1);
        check("b2b_b_word", out_word0, 16'h1234);
        check("b2b_b_mask", out_mask0, 16'hFFFF);
        check("b2b_period", cyc_b - cyc_a, 17);
        in_valid = 1'b0;
        tick();
        check("b2b_end_valid", out_valid0, 0);
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmx16_deser.md
Name: dmx16_deser

Overview:
- 1-to-16 demultiplexing deserializer; the write-side counterpart of the 16:1 strobed selector in the lgsynth91 datapath set.
- Accepts one data bit per handshake and steers it into one of 16 word positions, either by an explicit 4-bit select or by an internal scan counter.
- Presents the assembled 16-bit word with a per-bit written mask on a valid/ready output port.
- Bridges serial selector outputs back into parallel registers.

Parameters:
- WIDTH, 16, number of demux positions; power of 2, range 2..64.
- SEL_W, log2(WIDTH), select width; localparam, derived only.
- DATA_INV, 0, when 1 the captured bit is stored inverted, matching the inverted-output selector polarity.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, reset; one clock; reset is asynchronous and active-low.
- en_n, in, 1, active-low enable; when 1, in_ready=0 and no bit is accepted.
- in_valid, in, 1, a bit is offered.
- in_ready, out, 1, block accepts a bit this cycle.
- in_data, in, 1, serial bit.
- in_sel, in, SEL_W, target position (addressed mode).
- in_mode, in, 1, 0=addressed, 1=scan (position from internal counter).
- in_flush, in, 1, close the current word early.
- out_valid, out, 1, assembled word available.
- out_ready, in, 1, consumer takes the word.
- out_word, out, WIDTH, assembled word.
- out_mask, out, WIDTH, bit i=1 if position i was written this word.

Behaviour:
- Reset (async, rst_n=0): state=FILL; out_valid=0, out_word=0, out_mask=0, scan counter cnt=0. in_ready follows its combinational rule, so it reads 1 after reset only when en_n=0.
- Reset mid-word discards all partial data; no output handshake completes.
- States: FILL, HOLD.
- in_ready = (state==FILL) & ~en_n. A bit is accepted on a cycle where in_valid & in_ready.
- FILL accept:
  - pos = in_mode ? cnt : in_sel.
  - out_word[pos] <= in_data ^ DATA_INV; out_mask[pos] <= 1.
  - In scan mode cnt increments mod WIDTH. In addressed mode cnt is unchanged.
- Rewriting a position already written overwrites the data bit; the mask bit stays 1.
- FILL -> HOLD when either:
  - (a) the mask after this accept is all ones, or
  - (b) in_flush=1 on a cycle with en_n=0; the flush takes effect whether or not a bit is accepted that cycle, and an accepted bit is included.
- Flush with an empty mask and no accept is ignored (stay FILL).
- out_valid=1 exactly while in HOLD. out_word and out_mask are stable throughout HOLD.
- HOLD -> FILL when out_ready=1: next cycle out_valid=0, out_word=0, out_mask=0, cnt=0.
- Latency: out_valid rises the cycle after the completing accept. Minimum turnaround is one bubble cycle (in_ready=0 during HOLD), so peak throughput is WIDTH bits per WIDTH+1 cycles.
- Mixing modes within one word is legal; the mask governs completion.
- in_sel is ignored in scan mode. in_mode, in_sel and in_data are don't-care when no accept occurs.
- en_n=1 freezes FILL entirely (no accept, no flush). en_n has no effect in HOLD.

Decomposition:
- Shared package dmx_pkg holds: the mode encoding constants (MODE_ADDR=0, MODE_SCAN=1), the state enum {FILL, HOLD}, and the WIDTH-to-SEL_W function.
- One natural sub-module, dmx_pos_decode: SEL_W-to-one-hot decoder producing the write-enable vector. Everything else stays in the top.

Test Plan:
- Scan fill: en_n=0, in_mode=1, 16 bits 1,0,1,1,0,0,0,0,1,1,1,1,0,0,1,0 with out_ready=0 -> out_valid rises the cycle after the 16th accept; out_word=0x4F0D, out_mask=0xFFFF, in_ready=0 while held. Assert out_ready -> next cycle out_valid=0, word and mask 0.
- Addressed partial + flush: write in_sel=3 data 1, then in_sel=15 data 1, then flush on a cycle with no bit -> out_word=0x8008, out_mask=0x8008. Flush with an empty mask -> no out_valid.
- Overwrite and DATA_INV=1: in_sel=5 data 1, then in_sel=5 data 0, then flush -> out_word=0x0020, out_mask=0x0020.
- Enable gating: en_n=1 with in_valid=1 for 10 cycles -> in_ready=0, mask unchanged. A flush asserted during those cycles is ignored.
- Async reset mid-word: after 7 scan bits, pulse rst_n low between clock edges -> outputs 0 immediately. The next scan word starts at position 0.
- Back-to-back scan words with out_ready tied 1 -> each word spans exactly 17 cycles; words match the driven patterns with no bit loss.
